// File: rtl/cic_decim.sv
// ---------------------------------------------------------------------------------------------
// cic_decim: PDM-to-PCM CIC decimator (first stage of the mic receive chain, feeds hb1).
//
// A 1-bit PDM stream (1 -> +1, 0 -> -1) is integrated by CIC_ORDER integrators at the PDM
// rate. The stream is decimated by R = 2**DEC_LOG2, passed through CIC_ORDER pipelined comb
// stages (M = 1), scaled by an arithmetic right shift and saturated to a signed OUT_W sample.
// All integrator and comb arithmetic wraps modulo 2**ACC_W (Hogenauer), which keeps the comb
// output exact.
//
// Ports
//   clk        in   1      system clock
//   reset      in   1      asynchronous, active-high reset
//   pdm_bit    in   1      PDM sample, consumed only when pdm_valid is high
//   pdm_valid  in   1      one-cycle PDM strobe
//   y_out      out  OUT_W  signed Q15 PCM sample, held until the next output
//   y_valid    out  1      one-cycle strobe marking a new y_out
//
// Optional feature macro: CIC_DC_BLOCK_EN
//   When defined, a first-order DC blocker d[n] = v[n] - v[n-1] + d[n-1] - (d[n-1] >>> 8)
//   follows saturation (24-bit state, saturated to OUT_W) and adds one clk of latency.
// ---------------------------------------------------------------------------------------------
module cic_decim #(
    parameter int unsigned CIC_ORDER = 4,
    parameter int unsigned DEC_LOG2  = 4,
    parameter int unsigned OUT_W     = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    pdm_bit,
    input  logic                    pdm_valid,
    output logic signed [OUT_W-1:0] y_out,
    output logic                    y_valid
);

    localparam int unsigned ACC_W    = 2 + CIC_ORDER * DEC_LOG2;
    localparam int          SH       = int'(CIC_ORDER * DEC_LOG2) - int'(OUT_W - 1);
    localparam int unsigned SETTLE_W = $clog2(CIC_ORDER + 1);

    localparam logic signed [ACC_W-1:0]  ACC_ONE     = ACC_W'(1);
    localparam logic signed [ACC_W-1:0]  ACC_MONE    = {ACC_W{1'b1}};
    localparam logic signed [ACC_W-1:0]  SAT_MAX     = ACC_W'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0]  SAT_MIN     = ~SAT_MAX;
    localparam logic [DEC_LOG2-1:0]      PH_ONE      = DEC_LOG2'(1);
    localparam logic [SETTLE_W-1:0]      SETTLE_ONE  = SETTLE_W'(1);
    localparam logic [SETTLE_W-1:0]      SETTLE_DONE = SETTLE_W'(CIC_ORDER);

    // Integrators, phase counter
    logic signed [ACC_W-1:0] integ_q [CIC_ORDER];
    logic signed [ACC_W-1:0] integ_d [CIC_ORDER];
    logic [DEC_LOG2-1:0]     phase_q;
    logic                    dec_stb;

    // Comb pipeline: c_q[0] is the latched integrator output, c_q[k] the k-th comb output.
    // tok_q[k] marks that c_q[k] was just loaded with the in-flight sample.
    logic signed [ACC_W-1:0] c_q    [CIC_ORDER+1];
    logic signed [ACC_W-1:0] prev_q [CIC_ORDER];
    logic [CIC_ORDER:0]      tok_q;

    logic [SETTLE_W-1:0]     settle_q;
    logic                    settled;
    logic signed [ACC_W-1:0] scaled;
    logic signed [OUT_W-1:0] sat_val;

    assign dec_stb = pdm_valid && (phase_q == '1);
    assign settled = (settle_q == SETTLE_DONE);

    always_comb begin
        integ_d[0] = integ_q[0] + (pdm_bit ? ACC_ONE : ACC_MONE);
        for (int k = 1; k < int'(CIC_ORDER); k++) begin
            // Each stage adds the previous stage's registered value (register-to-register).
            integ_d[k] = integ_q[k] + integ_q[k-1];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < int'(CIC_ORDER); k++) integ_q[k] <= '0;
            phase_q <= '0;
        end else if (pdm_valid) begin
            for (int k = 0; k < int'(CIC_ORDER); k++) integ_q[k] <= integ_d[k];
            phase_q <= phase_q + PH_ONE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k <= int'(CIC_ORDER); k++) c_q[k] <= '0;
            for (int k = 0; k < int'(CIC_ORDER); k++) prev_q[k] <= '0;
            tok_q <= '0;
        end else begin
            tok_q <= {tok_q[CIC_ORDER-1:0], dec_stb};
            if (dec_stb) begin
                c_q[0] <= integ_d[CIC_ORDER-1];
            end
            for (int k = 1; k <= int'(CIC_ORDER); k++) begin
                if (tok_q[k-1]) begin
                    c_q[k]      <= c_q[k-1] - prev_q[k-1];
                    prev_q[k-1] <= c_q[k-1];
                end
            end
        end
    end

    always_comb begin
        scaled = c_q[CIC_ORDER] >>> SH;
        if (scaled > SAT_MAX) begin
            sat_val = SAT_MAX[OUT_W-1:0];
        end else if (scaled < SAT_MIN) begin
            sat_val = SAT_MIN[OUT_W-1:0];
        end else begin
            sat_val = scaled[OUT_W-1:0];
        end
    end

    // Counts the warm-up outputs whose comb history is still invalid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            settle_q <= '0;
        end else if (tok_q[CIC_ORDER] && !settled) begin
            settle_q <= settle_q + SETTLE_ONE;
        end
    end

`ifdef CIC_DC_BLOCK_EN
    localparam int unsigned DC_W = 24;
    localparam logic signed [DC_W-1:0] DC_MAX = DC_W'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [DC_W-1:0] DC_MIN = ~DC_MAX;

    logic signed [OUT_W-1:0] v_q;
    logic                    v_stb_q;
    logic                    v_ok_q;
    logic signed [DC_W-1:0]  v_prev_q;
    logic signed [DC_W-1:0]  d_q;
    logic signed [DC_W-1:0]  v_ext;
    logic signed [DC_W-1:0]  d_d;
    logic signed [OUT_W-1:0] d_sat;
    logic signed [OUT_W-1:0] y_q;
    logic                    y_valid_q;

    always_comb begin
        v_ext = {{(DC_W - OUT_W){v_q[OUT_W-1]}}, v_q};
        d_d   = v_ext - v_prev_q + d_q - (d_q >>> 8);
        if (d_d > DC_MAX) begin
            d_sat = DC_MAX[OUT_W-1:0];
        end else if (d_d < DC_MIN) begin
            d_sat = DC_MIN[OUT_W-1:0];
        end else begin
            d_sat = d_d[OUT_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v_q       <= '0;
            v_stb_q   <= 1'b0;
            v_ok_q    <= 1'b0;
            v_prev_q  <= '0;
            d_q       <= '0;
            y_q       <= '0;
            y_valid_q <= 1'b0;
        end else begin
            v_stb_q   <= tok_q[CIC_ORDER];
            y_valid_q <= 1'b0;
            if (tok_q[CIC_ORDER]) begin
                v_q    <= sat_val;
                v_ok_q <= settled;
            end
            // Blocker state advances on every decimated sample, warm-up ones included.
            if (v_stb_q) begin
                v_prev_q  <= v_ext;
                d_q       <= d_d;
                y_q       <= d_sat;
                y_valid_q <= v_ok_q;
            end
        end
    end
`else
    logic signed [OUT_W-1:0] y_q;
    logic                    y_valid_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            y_q       <= '0;
            y_valid_q <= 1'b0;
        end else begin
            y_valid_q <= 1'b0;
            if (tok_q[CIC_ORDER]) begin
                y_q       <= sat_val;
                y_valid_q <= settled;
            end
        end
    end
`endif

    assign y_out   = y_q;
    assign y_valid = y_valid_q;

endmodule

// File: tb/tb_cic_decim.sv
// ---------------------------------------------------------------------------------------------
// tb_cic_decim: self-checking bench for cic_decim. Expected samples come from a direct
// convolution of the +/-1 input with the CIC kernel (N-fold convolution of an R-tap boxcar),
// scaled and saturated, optionally followed by the DC blocker (CIC_DC_BLOCK_EN).
// ---------------------------------------------------------------------------------------------
module tb_cic_decim;

    localparam int N  = 4;
    localparam int L  = 4;
    localparam int R  = 16;
    localparam int OW = 16;
    localparam int SH = N * L - (OW - 1);
`ifdef CIC_DC_BLOCK_EN
    localparam int LAT = N + 2;
`else
    localparam int LAT = N + 1;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic pdm_bit = 1'b0;
    logic pdm_valid = 1'b0;
    logic signed [OW-1:0] y_out;
    logic y_valid;

    cic_decim #(
        .CIC_ORDER(N),
        .DEC_LOG2 (L),
        .OUT_W    (OW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .pdm_bit  (pdm_bit),
        .pdm_valid(pdm_valid),
        .y_out    (y_out),
        .y_valid  (y_valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int x_q[$];
    int e0_q[$];
    int out_q[$];
    int out_cyc_q[$];
    int exp_q[$];
    int h[$];
    int tests = 0;
    int fails = 0;
    int dbl_cnt = 0;
    logic prev_v = 1'b0;

    always @(negedge clk) begin
        if (y_valid) begin
            out_q.push_back(int'(y_out));
            out_cyc_q.push_back(cyc);
        end
        if (y_valid && prev_v) dbl_cnt++;
        prev_v = y_valid;
    end

    function automatic int sat16(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    task automatic build_kernel();
        int tmp[$];
        h.delete();
        h.push_back(1);
        for (int s = 0; s < N; s++) begin
            tmp.delete();
            for (int i = 0; i < h.size() + R - 1; i++) tmp.push_back(0);
            for (int i = 0; i < h.size(); i++)
                for (int j = 0; j < R; j++) tmp[i+j] += h[i];
            h = tmp;
        end
    endtask

    // One expected sample per completed block of R inputs (warm-up ones included).
    task automatic build_exp();
        int acc, idx, nb, v, vp, dp, d;
        exp_q.delete();
        vp = 0;
        dp = 0;
        for (int b = 0; b < e0_q.size(); b++) begin
            nb  = R * b + R - 1;
            acc = 0;
            for (int j = 0; j < h.size(); j++) begin
                idx = nb - (N - 1) - j;
                if (idx >= 0 && idx < x_q.size()) acc += h[j] * x_q[idx];
            end
            v = sat16(acc >>> SH);
`ifdef CIC_DC_BLOCK_EN
            d  = v - vp + dp - (dp >>> 8);
            vp = v;
            dp = d;
            v  = sat16(d);
`else
            d = 0;
`endif
            exp_q.push_back(v);
        end
    endtask

    // mode: 0 ones, 1 zeros, 2 alternating, 3 random. gap 0 = random spacing 1..3 clk.
    task automatic drive(input int mode, input int gap, input int nsamp, input bit drain);
        int bit_v, g;
        for (int i = 0; i < nsamp; i++) begin
            @(negedge clk);
            case (mode)
                0:       bit_v = 1;
                1:       bit_v = 0;
                2:       bit_v = (x_q.size() % 2 == 0) ? 1 : 0;
                default: bit_v = int'($urandom_range(0, 1));
            endcase
            pdm_bit   = bit_v[0];
            pdm_valid = 1'b1;
            x_q.push_back(bit_v != 0 ? 1 : -1);
            if (x_q.size() % R == 0) e0_q.push_back(cyc + 1);
            g = (gap == 0) ? int'($urandom_range(1, 3)) : gap;
            for (int k = 1; k < g; k++) begin
                @(negedge clk);
                pdm_valid = 1'b0;
            end
        end
        if (drain) begin
            @(negedge clk);
            pdm_valid = 1'b0;
            repeat (12) @(negedge clk);
        end
    endtask

    task automatic clear_logs();
        x_q.delete();
        e0_q.delete();
        out_q.delete();
        out_cyc_q.delete();
        dbl_cnt = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset     = 1'b1;
        pdm_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        clear_logs();
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        tests++;
        if (y_out !== 16'sd0) $display("FAIL reset_y: got %0d expected 0", y_out);
        if (y_out !== 16'sd0) fails++;
        tests++;
        if (y_valid !== 1'b0) begin
            $display("FAIL reset_valid: got %b expected 0", y_valid);
            fails++;
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        clear_logs();
    endtask

    task automatic test_all_ones();
        do_reset();
        drive(0, 4, R * 10, 1'b1);
        build_exp();
        tests++;
        if (out_q.size() != exp_q.size() - N) begin
            $display("FAIL ones_count: got %0d expected %0d", out_q.size(), exp_q.size() - N);
            fails++;
        end
        for (int b = N; b < exp_q.size() && b - N < out_q.size(); b++) begin
            tests++;
            if (out_q[b-N] !== exp_q[b]) begin
                $display("FAIL ones_val[%0d]: got %0d expected %0d", b, out_q[b-N], exp_q[b]);
                fails++;
            end
            tests++;
            if (out_cyc_q[b-N] !== e0_q[b] + LAT) begin
                $display("FAIL ones_lat[%0d]: got %0d expected %0d", b, out_cyc_q[b-N],
                         e0_q[b] + LAT);
                fails++;
            end
        end
`ifndef CIC_DC_BLOCK_EN
        tests++;
        if (out_q.size() == 0 || out_q[out_q.size()-1] !== 32767) begin
            $display("FAIL ones_fullscale: got %0d expected 32767",
                     out_q.size() == 0 ? 0 : out_q[out_q.size()-1]);
            fails++;
        end
`endif
    endtask

    task automatic test_all_zeros();
        do_reset();
        drive(1, 1, 4096, 1'b1);
        build_exp();
        tests++;
        if (out_q.size() != exp_q.size() - N) begin
            $display("FAIL zeros_count: got %0d expected %0d", out_q.size(), exp_q.size() - N);
            fails++;
        end
        for (int b = N; b < exp_q.size() && b - N < out_q.size(); b++) begin
            tests++;
            if (out_q[b-N] !== exp_q[b]) begin
                $display("FAIL zeros_val[%0d]: got %0d expected %0d", b, out_q[b-N], exp_q[b]);
                fails++;
            end
`ifndef CIC_DC_BLOCK_EN
            tests++;
            if (out_q[b-N] !== -32768) begin
                $display("FAIL zeros_fullscale[%0d]: got %0d expected -32768", b, out_q[b-N]);
                fails++;
            end
`endif
        end
    endtask

    task automatic test_alternating();
        do_reset();
        drive(2, 2, R * 12, 1'b1);
        build_exp();
        tests++;
        if (out_q.size() != exp_q.size() - N) begin
            $display("FAIL alt_count: got %0d expected %0d", out_q.size(), exp_q.size() - N);
            fails++;
        end
        for (int b = N; b < exp_q.size() && b - N < out_q.size(); b++) begin
            tests++;
            if (out_q[b-N] !== exp_q[b]) begin
                $display("FAIL alt_val[%0d]: got %0d expected %0d", b, out_q[b-N], exp_q[b]);
                fails++;
            end
`ifndef CIC_DC_BLOCK_EN
            tests++;
            if (out_q[b-N] !== 0) begin
                $display("FAIL alt_zero[%0d]: got %0d expected 0", b, out_q[b-N]);
                fails++;
            end
`endif
        end
    endtask

    task automatic test_random();
        do_reset();
        drive(3, 0, R * 40, 1'b1);
        build_exp();
        tests++;
        if (out_q.size() != exp_q.size() - N) begin
            $display("FAIL rand_count: got %0d expected %0d", out_q.size(), exp_q.size() - N);
            fails++;
        end
        for (int b = N; b < exp_q.size() && b - N < out_q.size(); b++) begin
            tests++;
            if (out_q[b-N] !== exp_q[b]) begin
                $display("FAIL rand_val[%0d]: got %0d expected %0d", b, out_q[b-N], exp_q[b]);
                fails++;
            end
            tests++;
            if (out_cyc_q[b-N] !== e0_q[b] + LAT) begin
                $display("FAIL rand_lat[%0d]: got %0d expected %0d", b, out_cyc_q[b-N],
                         e0_q[b] + LAT);
                fails++;
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        drive(0, 1, R * 8, 1'b1);
        build_exp();
        tests++;
        if (out_q.size() != exp_q.size() - N) begin
            $display("FAIL b2b_count: got %0d expected %0d", out_q.size(), exp_q.size() - N);
            fails++;
        end
        for (int b = N; b < exp_q.size() && b - N < out_q.size(); b++) begin
            tests++;
            if (out_cyc_q[b-N] !== e0_q[b] + LAT) begin
                $display("FAIL b2b_lat[%0d]: got %0d expected %0d", b, out_cyc_q[b-N],
                         e0_q[b] + LAT);
                fails++;
            end
        end
        tests++;
        if (dbl_cnt !== 0) begin
            $display("FAIL b2b_pulse: got %0d multi-cycle strobes expected 0", dbl_cnt);
            fails++;
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        drive(0, 1, R * 6 + 2, 1'b0);
        build_exp();
        @(posedge clk);
        #2;
        tests++;
        if (int'(y_out) !== exp_q[N]) begin
            $display("FAIL mid_pre: got %0d expected %0d", y_out, exp_q[N]);
            fails++;
        end
        reset = 1'b1;
        #1;
        tests++;
        if (y_out !== 16'sd0 || y_valid !== 1'b0) begin
            $display("FAIL mid_reset: got y=%0d v=%b expected y=0 v=0", y_out, y_valid);
            fails++;
        end
        pdm_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        clear_logs();
        drive(0, 1, R * 6, 1'b1);
        build_exp();
        tests++;
        if (out_q.size() != 2) begin
            $display("FAIL mid_count: got %0d expected 2", out_q.size());
            fails++;
        end
        for (int b = N; b < exp_q.size() && b - N < out_q.size(); b++) begin
            tests++;
            if (out_q[b-N] !== exp_q[b] || out_cyc_q[b-N] !== e0_q[b] + LAT) begin
                $display("FAIL mid_out[%0d]: got %0d@%0d expected %0d@%0d", b, out_q[b-N],
                         out_cyc_q[b-N], exp_q[b], e0_q[b] + LAT);
                fails++;
            end
        end
    endtask

`ifdef CIC_DC_BLOCK_EN
    task automatic test_dc_decay();
        int last;
        do_reset();
        drive(0, 1, R * 2100, 1'b1);
        build_exp();
        tests++;
        if (out_q.size() != exp_q.size() - N) begin
            $display("FAIL dc_count: got %0d expected %0d", out_q.size(), exp_q.size() - N);
            fails++;
        end
        for (int b = N; b < exp_q.size() && b - N < out_q.size(); b++) begin
            tests++;
            if (out_q[b-N] !== exp_q[b]) begin
                $display("FAIL dc_val[%0d]: got %0d expected %0d", b, out_q[b-N], exp_q[b]);
                fails++;
            end
        end
        last = (out_q.size() == 0) ? 99999 : out_q[out_q.size()-1];
        tests++;
        // The >>> 8 leak term truncates, so the residue settles below 256 rather than at 0.
        if (last >= 256 || last <= -256) begin
            $display("FAIL dc_residue: got %0d expected |y| < 256", last);
            fails++;
        end
    endtask
`endif

    initial begin
        build_kernel();
        test_reset();
        test_all_ones();
        test_all_zeros();
        test_alternating();
        test_random();
        test_back_to_back();
        test_reset_mid();
`ifdef CIC_DC_BLOCK_EN
        test_dc_decay();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
